// File: rtl/ff_bank_multimode_if.sv
// rtl/ff_bank_multimode_if.sv - control/data bundle for ff_bank_multimode (toggle_cnt with FF_BANK_TOGGLE_CNT_EN)
interface ff_bank_multimode_if #(
    parameter int WIDTH = 4
`ifdef FF_BANK_TOGGLE_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
);
    logic                 en;
    logic [2*WIDTH-1:0]   mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 err_clr;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     qbar;
    logic [WIDTH-1:0]     err;
`ifdef FF_BANK_TOGGLE_CNT_EN
    logic [CNT_W-1:0]     toggle_cnt;

    modport master (output en, mode, a, b, err_clr, input q, qbar, err, toggle_cnt);
    modport slave  (input en, mode, a, b, err_clr, output q, qbar, err, toggle_cnt);
`else
    modport master (output en, mode, a, b, err_clr, input q, qbar, err);
    modport slave  (input en, mode, a, b, err_clr, output q, qbar, err);
`endif
endinterface

// File: rtl/ff_bank_multimode.sv
// rtl/ff_bank_multimode.sv - per-bit D/RS/JK/T flip-flop bank; FF_BANK_TOGGLE_CNT_EN adds a saturating transition counter
module ff_bank_multimode #(
    parameter int                 WIDTH   = 4,
    parameter logic [WIDTH-1:0]   RESET_Q = '0,
    parameter int                 CNT_W   = 8
) (
    input  logic              clk,
    input  logic              clear,
    ff_bank_multimode_if.slave bus
);
    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_RS = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("ff_bank_multimode: WIDTH and CNT_W must be >= 1");
    end

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] err_r;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] forbidden;

    always_comb begin
        q_next    = q_r;
        forbidden = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (bus.mode[2*i +: 2])
                MODE_D:  q_next[i] = bus.a[i];
                MODE_RS: begin
                    case ({bus.a[i], bus.b[i]})
                        2'b10:   q_next[i] = 1'b1;
                        2'b01:   q_next[i] = 1'b0;
                        2'b11:   forbidden[i] = 1'b1;
                        default: q_next[i] = q_r[i];
                    endcase
                end
                MODE_JK: begin
                    case ({bus.a[i], bus.b[i]})
                        2'b10:   q_next[i] = 1'b1;
                        2'b01:   q_next[i] = 1'b0;
                        2'b11:   q_next[i] = ~q_r[i];
                        default: q_next[i] = q_r[i];
                    endcase
                end
                MODE_T:  q_next[i] = q_r[i] ^ bus.a[i];
                default: q_next[i] = q_r[i];
            endcase
        end
    end

    // A fresh forbidden input outranks err_clr on the same edge.
    always_ff @(posedge clk) begin
        if (clear) begin
            q_r   <= RESET_Q;
            err_r <= '0;
        end else begin
            if (bus.en) begin
                q_r <= q_next;
            end
            err_r <= (bus.err_clr ? '0 : err_r) | (bus.en ? forbidden : '0);
        end
    end

    assign bus.q    = q_r;
    assign bus.qbar = ~q_r;
    assign bus.err  = err_r;

`ifdef FF_BANK_TOGGLE_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_r <= '0;
        end else if (bus.en && (q_next != q_r) && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign bus.toggle_cnt = cnt_r;
`endif
endmodule

// File: tb/tb_ff_bank_multimode.sv
// tb/tb_ff_bank_multimode.sv - directed self-checking bench for ff_bank_multimode
module tb_ff_bank_multimode;
    logic clk = 1'b0;
    logic clear;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

`ifdef FF_BANK_TOGGLE_CNT_EN
    ff_bank_multimode_if #(.WIDTH(4), .CNT_W(8)) bus ();
`else
    ff_bank_multimode_if #(.WIDTH(4)) bus ();
`endif

    ff_bank_multimode #(.WIDTH(4), .RESET_Q(4'b0000), .CNT_W(8)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_next(input logic [7:0] m, input logic [3:0] av,
                                            input logic [3:0] bv, input logic [3:0] qv);
        logic [3:0] n;
        for (int i = 0; i < 4; i++) begin
            case (m[2*i +: 2])
                2'b00: n[i] = av[i];
                2'b01: n[i] = (av[i] && !bv[i]) ? 1'b1 : (!av[i] && bv[i]) ? 1'b0 : qv[i];
                2'b10: n[i] = (av[i] && bv[i]) ? ~qv[i] : av[i] ? 1'b1 : bv[i] ? 1'b0 : qv[i];
                default: n[i] = av[i] ? ~qv[i] : qv[i];
            endcase
        end
        return n;
    endfunction

    function automatic logic [3:0] ref_forb(input logic [7:0] m, input logic [3:0] av,
                                            input logic [3:0] bv);
        logic [3:0] f;
        for (int i = 0; i < 4; i++) f[i] = (m[2*i +: 2] == 2'b01) && av[i] && bv[i];
        return f;
    endfunction

    initial begin
        logic [3:0] mq;
        logic [3:0] merr;
        logic [3:0] av;
        logic [3:0] bv;

        clear = 1'b1;
        bus.en = 1'b1;
        bus.mode = 8'h00;
        bus.a = 4'hF;
        bus.b = 4'h0;
        bus.err_clr = 1'b0;
        step();
        check("rst_q", 32'(bus.q), 32'h0);
        check("rst_qbar", 32'(bus.qbar), 32'hF);
        check("rst_err", 32'(bus.err), 32'h0);
`ifdef FF_BANK_TOGGLE_CNT_EN
        check("rst_cnt", 32'(bus.toggle_cnt), 32'h0);
`endif
        clear = 1'b0;

        bus.a = 4'b1010;
        step();
        check("d_load", 32'(bus.q), 32'hA);
        check("d_qbar", 32'(bus.qbar), 32'h5);
        bus.en = 1'b0;
        bus.a = 4'b0101;
        step();
        check("d_hold", 32'(bus.q), 32'hA);

        bus.en = 1'b1;
        bus.mode = 8'h55;
        bus.a = 4'h0; bus.b = 4'hF; step();
        check("rs_reset_all", 32'(bus.q), 32'h0);
        bus.a = 4'b0001; bus.b = 4'b0000; step();
        check("rs_set", 32'(bus.q), 32'h1);
        bus.a = 4'b0000; bus.b = 4'b0001; step();
        check("rs_reset", 32'(bus.q), 32'h0);
        bus.a = 4'b0010; bus.b = 4'b0010; step();
        check("rs_forb_q", 32'(bus.q), 32'h0);
        check("rs_forb_err", 32'(bus.err), 32'h2);
        bus.a = 4'h0; bus.b = 4'h0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rs_err_sticky", 32'(bus.err), 32'h2);
        end
        bus.en = 1'b0; bus.a = 4'hF; bus.b = 4'hF; step();
        check("rs_dis_q", 32'(bus.q), 32'h0);
        check("rs_dis_err", 32'(bus.err), 32'h2);
        bus.a = 4'h0; bus.b = 4'h0; bus.err_clr = 1'b1; step();
        check("rs_errclr_dis", 32'(bus.err), 32'h0);
        bus.en = 1'b1; bus.err_clr = 1'b0; bus.a = 4'b0011; bus.b = 4'b0011; step();
        check("rs_err_two", 32'(bus.err), 32'h3);
        bus.a = 4'b0010; bus.b = 4'b0010; bus.err_clr = 1'b1; step();
        check("rs_set_wins", 32'(bus.err), 32'h2);
        bus.a = 4'h0; bus.b = 4'h0; step();
        check("rs_errclr", 32'(bus.err), 32'h0);
        bus.err_clr = 1'b0;

        bus.mode = 8'hAA; bus.a = 4'hF; bus.b = 4'hF;
        step(); check("jk_tog1", 32'(bus.q), 32'hF);
        step(); check("jk_tog2", 32'(bus.q), 32'h0);
        step(); check("jk_tog3", 32'(bus.q), 32'hF);
        bus.a = 4'b0000; bus.b = 4'b0101; step();
        check("jk_reset", 32'(bus.q), 32'hA);
        bus.mode = 8'hFF; bus.a = 4'b0011; bus.b = 4'hF;
        step(); check("t_tog1", 32'(bus.q), 32'h9);
        step(); check("t_tog2", 32'(bus.q), 32'hA);
        bus.a = 4'h0; step(); check("t_hold", 32'(bus.q), 32'hA);

        clear = 1'b1; step(); clear = 1'b0;
        mq = 4'h0; merr = 4'h0;
        bus.mode = 8'hE4;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                av = 4'(ai); bv = 4'(bi);
                bus.a = av; bus.b = bv;
                bus.err_clr = (bi == 5);
                merr = (bus.err_clr ? 4'h0 : merr) | ref_forb(8'hE4, av, bv);
                mq = ref_next(8'hE4, av, bv, mq);
                step();
                check("mix_q", 32'(bus.q), 32'(mq));
                check("mix_err", 32'(bus.err), 32'(merr));
            end
        end
        bus.err_clr = 1'b1; bus.a = 4'h0; bus.b = 4'h0; step();
        check("mix_errclr", 32'(bus.err), 32'h0);
        bus.err_clr = 1'b1; bus.a = 4'b0010; bus.b = 4'b0010; step();
        check("mix_set_wins", 32'(bus.err), 32'h2);
        bus.err_clr = 1'b0;

`ifdef FF_BANK_TOGGLE_CNT_EN
        clear = 1'b1; step(); clear = 1'b0;
        bus.mode = 8'hFF; bus.b = 4'h0; bus.en = 1'b1;
        bus.a = 4'h0;
        for (int k = 0; k < 3; k++) step();
        check("cnt_hold_edges", 32'(bus.toggle_cnt), 32'd0);
        bus.a = 4'b0001;
        for (int k = 0; k < 10; k++) step();
        check("cnt_ten", 32'(bus.toggle_cnt), 32'd10);
        bus.en = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check("cnt_dis", 32'(bus.toggle_cnt), 32'd10);
        bus.en = 1'b1;
        for (int k = 0; k < 120; k++) step();
        check("cnt_mid", 32'(bus.toggle_cnt), 32'd130);
        clear = 1'b1; step(); clear = 1'b0;
        check("cnt_clear", 32'(bus.toggle_cnt), 32'd0);
        for (int k = 0; k < 300; k++) step();
        check("cnt_sat", 32'(bus.toggle_cnt), 32'd255);
        step();
        check("cnt_sat_hold", 32'(bus.toggle_cnt), 32'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
